// File: rtl/fd_em_hazard_ctrl_if.sv
// FD->EM hazard controller bundle: FD decode fields, memory/branch
// status in, pipeline enables, bubble, forwarding selects and status out.
interface fd_em_hazard_ctrl_if;
    logic        id_valid;
    logic [2:0]  id_rs1;
    logic [2:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [2:0]  id_rd;
    logic        id_reg_wb;
    logic        id_mem_re;
    logic        id_mem_we;
    logic        mem_ready;
    logic        branch_taken;
    logic        fd_en;
    logic        fdem_en;
    logic        fdem_bubble;
    logic [1:0]  fwdA_sel;
    logic [1:0]  fwdB_sel;
    logic        timeout_err;
    logic [15:0] stall_cycles;

    // Controller side: consumes decode/status, commands the pipe.
    modport master (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  id_rd, id_reg_wb, id_mem_re, id_mem_we,
        input  mem_ready, branch_taken,
        output fd_en, fdem_en, fdem_bubble, fwdA_sel, fwdB_sel,
        output timeout_err, stall_cycles
    );

    // Pipeline side: supplies decode/status, obeys the controls.
    modport slave (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output id_rd, id_reg_wb, id_mem_re, id_mem_we,
        output mem_ready, branch_taken,
        input  fd_en, fdem_en, fdem_bubble, fwdA_sel, fwdB_sel,
        input  timeout_err, stall_cycles
    );
endinterface

// File: rtl/fd_em_hazard_ctrl.sv
// FD->EM sequencing: load-use stall, EM/WB forwarding, memory freeze, branch flush.
// Optional stall-cycle counter enabled by defining HAZ_PERF_CNT_EN.
module fd_em_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter bit R0_HARDWIRED = 1'b0
) (
    input logic                 clk,
    input logic                 reset,
    fd_em_hazard_ctrl_if.master hz
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam logic [8:0] TMO_LIMIT  = 9'(MEM_TIMEOUT);

    state_t     state;

    logic [2:0] em_rd;
    logic       em_wb;
    logic       em_re;
    logic       em_we;
    logic [2:0] wb_rd;
    logic       wb_wb;

    logic       pending;
    logic [2:0] flush_cnt;
    logic [7:0] wait_cnt;
    logic       timeout_q;
    logic [1:0] fa_hold;
    logic [1:0] fb_hold;

    logic       busy;
    logic       frozen;
    logic       flushing;
    logic       lu;
    logic       br;
    logic       rs1_em;
    logic       rs2_em;
    logic       rs1_wb;
    logic       rs2_wb;
    logic [1:0] fa_live;
    logic [1:0] fb_live;
    logic       fd_en_c;
    logic       fdem_en_c;
    logic       bubble_c;

    // Register-address match; r0 optionally never matches.
    function automatic logic hit(
        input logic [2:0] rs,
        input logic [2:0] rd
    );
        return (rs == rd) && !(R0_HARDWIRED && (rd == 3'd0));
    endfunction

    assign rs1_em = hit(hz.id_rs1, em_rd);
    assign rs2_em = hit(hz.id_rs2, em_rd);
    assign rs1_wb = hit(hz.id_rs1, wb_rd);
    assign rs2_wb = hit(hz.id_rs2, wb_rd);

    assign busy     = (em_re | em_we) & ~hz.mem_ready;
    assign frozen   = busy & (state == MEM_WAIT);
    assign flushing = (state == FLUSH);
    assign br       = hz.branch_taken | pending;

    assign lu = ~flushing & hz.id_valid & em_re & em_wb &
                ((hz.id_use_rs1 & rs1_em) |
                 (hz.id_use_rs2 & rs2_em));

    assign fa_live = (em_wb & ~em_re & rs1_em) ? 2'b01 :
                     (wb_wb & rs1_wb)          ? 2'b10 :
                                                 2'b00;

    assign fb_live = (em_wb & ~em_re & rs2_em) ? 2'b01 :
                     (wb_wb & rs2_wb)          ? 2'b10 :
                                                 2'b00;

    // Pipe controls: memory freeze beats flush beats load-use bubble.
    always_comb begin
        fd_en_c   = 1'b1;
        fdem_en_c = 1'b1;
        bubble_c  = 1'b0;
        if (busy) begin
            fd_en_c   = 1'b0;
            fdem_en_c = 1'b0;
        end else if (flushing) begin
            bubble_c  = 1'b1;
        end else if (lu) begin
            fd_en_c   = 1'b0;
            bubble_c  = 1'b1;
        end
    end

    assign hz.fd_en       = fd_en_c;
    assign hz.fdem_en     = fdem_en_c;
    assign hz.fdem_bubble = bubble_c;
    assign hz.fwdA_sel    = frozen ? fa_hold : fa_live;
    assign hz.fwdB_sel    = frozen ? fb_hold : fb_live;
    assign hz.timeout_err = timeout_q;

    // State, shadow pipeline, flush/wait counters and sticky timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            em_rd     <= 3'd0;
            em_wb     <= 1'b0;
            em_re     <= 1'b0;
            em_we     <= 1'b0;
            wb_rd     <= 3'd0;
            wb_wb     <= 1'b0;
            pending   <= 1'b0;
            flush_cnt <= 3'd0;
            wait_cnt  <= 8'd0;
            timeout_q <= 1'b0;
            fa_hold   <= 2'b00;
            fb_hold   <= 2'b00;
        end else begin
            fa_hold <= hz.fwdA_sel;
            fb_hold <= hz.fwdB_sel;
            if (busy) begin
                state   <= MEM_WAIT;
                pending <= pending | hz.branch_taken | flushing;
                if (wait_cnt != 8'hFF) begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
                if (({1'b0, wait_cnt} + 9'd1) >= TMO_LIMIT) begin
                    timeout_q <= 1'b1;
                end
            end else begin
                wait_cnt <= 8'd0;
                pending  <= 1'b0;
                wb_rd    <= em_rd;
                wb_wb    <= em_wb;
                if (bubble_c | ~hz.id_valid) begin
                    em_rd <= 3'd0;
                    em_wb <= 1'b0;
                    em_re <= 1'b0;
                    em_we <= 1'b0;
                end else begin
                    em_rd <= hz.id_rd;
                    em_wb <= hz.id_reg_wb;
                    em_re <= hz.id_mem_re;
                    em_we <= hz.id_mem_we;
                end
                if (br) begin
                    state     <= FLUSH;
                    flush_cnt <= FLUSH_LOAD;
                end else if (flushing) begin
                    if (flush_cnt <= 3'd1) begin
                        state <= RUN;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end else if (lu) begin
                    state <= LU_STALL;
                end else begin
                    state <= RUN;
                end
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_q;

    // Saturating count of cycles where FD is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= 16'h0000;
        end else if (!fd_en_c && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign hz.stall_cycles = stall_q;
`else
    assign hz.stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_fd_em_hazard_ctrl.sv
// Bench for fd_em_hazard_ctrl: directed hazard scenarios then random traffic,
// every cycle compared against an instruction-level pipeline model.
module tb_fd_em_hazard_ctrl;

    localparam int FC  = 2;
    localparam int TMO = 8;
    localparam bit R0  = 1'b1;
`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fd_em_hazard_ctrl_if bus();

    fd_em_hazard_ctrl #(
        .FLUSH_CYCLES(FC),
        .MEM_TIMEOUT(TMO),
        .R0_HARDWIRED(R0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hz(bus)
    );

    typedef struct packed {
        logic [2:0] rd;
        logic       wb;
        logic       re;
        logic       we;
    } slot_t;

    int n_chk = 0;
    int n_fail = 0;

    slot_t      m_em, m_wb;
    bit         m_wait, m_flush, m_pend, m_tmo;
    int         m_left, m_waits, m_stalls;
    logic [1:0] m_fa_hold, m_fb_hold;

    logic        o_fd, o_en, o_bub, o_tmo;
    logic [1:0]  o_fa, o_fb;
    logic [15:0] o_stall;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input logic [2:0] rs, input logic [2:0] rd);
        return (rs == rd) && !(R0 && rd == 3'd0);
    endfunction

    function automatic logic [1:0] src(input logic [2:0] rs);
        if (m_em.wb && !m_em.re && hit(rs, m_em.rd)) return 2'b01;
        if (m_wb.wb && hit(rs, m_wb.rd)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic m_reset();
        m_em = '0; m_wb = '0;
        m_wait = 0; m_flush = 0; m_pend = 0; m_tmo = 0;
        m_left = 0; m_waits = 0; m_stalls = 0;
        m_fa_hold = 2'b00; m_fb_hold = 2'b00;
    endtask

    task automatic set_fd(input bit v, input logic [2:0] r1,
                          input logic [2:0] r2, input bit u1, input bit u2,
                          input logic [2:0] rd, input bit wb, input bit re,
                          input bit we);
        bus.id_valid = v; bus.id_rs1 = r1; bus.id_rs2 = r2;
        bus.id_use_rs1 = u1; bus.id_use_rs2 = u2; bus.id_rd = rd;
        bus.id_reg_wb = wb; bus.id_mem_re = re; bus.id_mem_we = we;
    endtask

    task automatic idle();
        set_fd(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.mem_ready = 1'b1;
        bus.branch_taken = 1'b0;
    endtask

    // One clock: check outputs at negedge against the model, advance the model.
    task automatic step();
        bit busy, lu, br;
        logic e_fd, e_en, e_bub;
        logic [1:0] fa, fb;
        @(negedge clk);
        busy = (m_em.re || m_em.we) && !bus.mem_ready;
        lu = !m_flush && bus.id_valid && m_em.re && m_em.wb &&
             ((bus.id_use_rs1 && hit(bus.id_rs1, m_em.rd)) ||
              (bus.id_use_rs2 && hit(bus.id_rs2, m_em.rd)));
        if (busy) begin
            e_fd = 0; e_en = 0; e_bub = 0;
        end else if (m_flush) begin
            e_fd = 1; e_en = 1; e_bub = 1;
        end else if (lu) begin
            e_fd = 0; e_en = 1; e_bub = 1;
        end else begin
            e_fd = 1; e_en = 1; e_bub = 0;
        end
        fa = (busy && m_wait) ? m_fa_hold : src(bus.id_rs1);
        fb = (busy && m_wait) ? m_fb_hold : src(bus.id_rs2);
        o_fd = bus.fd_en; o_en = bus.fdem_en; o_bub = bus.fdem_bubble;
        o_fa = bus.fwdA_sel; o_fb = bus.fwdB_sel;
        o_tmo = bus.timeout_err; o_stall = bus.stall_cycles;
        chk("fd_en", 16'(o_fd), 16'(e_fd));
        chk("fdem_en", 16'(o_en), 16'(e_en));
        chk("fdem_bubble", 16'(o_bub), 16'(e_bub));
        chk("fwdA_sel", 16'(o_fa), 16'(fa));
        chk("fwdB_sel", 16'(o_fb), 16'(fb));
        chk("timeout_err", 16'(o_tmo), 16'(m_tmo));
        chk("stall_cycles", o_stall, PERF ? 16'(m_stalls) : 16'h0000);
        m_fa_hold = fa;
        m_fb_hold = fb;
        if (!e_fd && m_stalls < 65535) m_stalls++;
        if (busy) begin
            m_wait = 1;
            m_pend = m_pend || bus.branch_taken || m_flush;
            m_flush = 0;
            if (m_waits < 255) m_waits++;
            if (m_waits >= TMO) m_tmo = 1;
        end else begin
            m_wait = 0;
            m_waits = 0;
            br = bus.branch_taken || m_pend;
            m_pend = 0;
            m_wb = m_em;
            if (e_bub || !bus.id_valid) m_em = '0;
            else m_em = '{rd: bus.id_rd, wb: bus.id_reg_wb,
                          re: bus.id_mem_re, we: bus.id_mem_we};
            if (br) begin
                m_flush = 1;
                m_left = FC;
            end else if (m_flush) begin
                m_left--;
                if (m_left == 0) m_flush = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset away from the edge, hold over one edge, release idle.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        chk({tag, "_rst_fd_en"}, 16'(bus.fd_en), 16'h1);
        chk({tag, "_rst_fdem_en"}, 16'(bus.fdem_en), 16'h1);
        chk({tag, "_rst_bubble"}, 16'(bus.fdem_bubble), 16'h0);
        chk({tag, "_rst_fwdA"}, 16'(bus.fwdA_sel), 16'h0);
        chk({tag, "_rst_fwdB"}, 16'(bus.fwdB_sel), 16'h0);
        chk({tag, "_rst_tmo"}, 16'(bus.timeout_err), 16'h0);
        chk({tag, "_rst_stall"}, bus.stall_cycles, 16'h0);
        @(posedge clk);
        #1;
        idle();
        reset = 1'b1;
        m_reset();
    endtask

    initial begin
        int lows;
        int kind;
        idle();
        m_reset();
        @(posedge clk);
        #1;
        do_reset("init");

        // ADD r2 then SUB r2,r2: both operands from EM, no stall.
        set_fd(1, 0, 0, 0, 0, 2, 1, 0, 0);
        step();
        set_fd(1, 2, 2, 1, 1, 4, 1, 0, 0);
        step();
        chk("alu_fwdA", 16'(o_fa), 16'h1);
        chk("alu_fwdB", 16'(o_fb), 16'h1);
        chk("alu_nostall", 16'(o_fd), 16'h1);

        // LOAD r3 then ADD reading r3: one bubble, then WB forward.
        set_fd(1, 0, 0, 0, 0, 3, 1, 1, 0);
        step();
        set_fd(1, 3, 5, 1, 0, 6, 1, 0, 0);
        step();
        chk("lu_fd_en", 16'(o_fd), 16'h0);
        chk("lu_bubble", 16'(o_bub), 16'h1);
        step();
        chk("lu_fwdA", 16'(o_fa), 16'h2);
        chk("lu_release", 16'(o_fd), 16'h1);

        // STORE held 4 cycles by memory.
        do_reset("st");
        set_fd(1, 1, 2, 1, 1, 0, 0, 0, 1);
        step();
        idle();
        lows = 0;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (!o_fd && !o_en) lows++;
        end
        bus.mem_ready = 1'b1;
        step();
        chk("st_freeze_cycles", 16'(lows), 16'd4);
        chk("st_release", 16'(o_en), 16'h1);
        chk("st_stall_cnt", o_stall, PERF ? 16'd4 : 16'd0);

        // Branch during memory wait: flush after completion.
        do_reset("br");
        set_fd(1, 0, 0, 0, 0, 1, 1, 1, 0);
        step();
        idle();
        bus.mem_ready = 1'b0;
        bus.branch_taken = 1'b1;
        step();
        chk("br_wait_bubble", 16'(o_bub), 16'h0);
        bus.branch_taken = 1'b0;
        step();
        bus.mem_ready = 1'b1;
        step();
        chk("br_exit_bubble", 16'(o_bub), 16'h0);
        step();
        chk("br_flush1", 16'(o_bub), 16'h1);
        step();
        chk("br_flush2", 16'(o_bub), 16'h1);
        step();
        chk("br_flush_end", 16'(o_bub), 16'h0);

        // Timeout after 8 wait cycles, sticky.
        do_reset("tmo");
        set_fd(1, 0, 0, 0, 0, 2, 1, 1, 0);
        step();
        idle();
        bus.mem_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (i == 8) chk("tmo_before", 16'(o_tmo), 16'h0);
            if (i == 9) chk("tmo_after", 16'(o_tmo), 16'h1);
        end
        bus.mem_ready = 1'b1;
        step();
        chk("tmo_sticky", 16'(o_tmo), 16'h1);

        // Reset in the middle of a memory wait.
        set_fd(1, 0, 0, 0, 0, 5, 1, 1, 0);
        step();
        idle();
        bus.mem_ready = 1'b0;
        step();
        step();
        do_reset("midwait");
        step();
        chk("midwait_run", 16'(o_fd & o_en), 16'h1);

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            if (c % 400 == 399) do_reset("rnd");
            kind = int'($urandom_range(0, 7));
            set_fd($urandom_range(0, 99) < 85,
                   3'($urandom), 3'($urandom),
                   1'($urandom), 1'($urandom), 3'($urandom),
                   kind <= 4, kind == 4 || kind == 7, kind == 5);
            bus.mem_ready = $urandom_range(0, 99) < 70;
            bus.branch_taken = $urandom_range(0, 99) < 8;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
